tm1638_responder: RTL and testbench

// - Peripheral-side emulator of the TM1638 LED & KEY 3-wire serial interface.
// - Bus: cs (STB, active low), sck (idles high), bidirectional DIO. Data is LSB first.
// - Receives data, address and display-control commands and maintains a 16-byte display memory.
// - Returns a 4-byte key-scan value on read commands.
// - Provides an on-FPGA target for the existing TM1638 controller and a bench model for it.

---
 rtl/tm1638_responder.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tm1638_responder                                            |
// | Description : Peripheral-side emulator of the TM1638 LED & KEY 3-wire     |
// |               serial interface (STB/CLK/DIO, LSB first). Accepts data,    |
// |               address and display-control commands, keeps a display      |
// |               memory and returns a key-scan snapshot on read commands.    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
// | Ports                                                                     |
// |   CLOCK_50     in   1             system clock                            |
// |   reset        in   1             synchronous reset, active low           |
// |   sck          in   1             serial clock from controller (idle hi)  |
// |   cs           in   1             chip select / STB, active low           |
// |   dio_i        in   1             DIO as seen at the pin                  |
// |   dio_o        out  1             DIO value to drive                      |
// |   dio_e        out  1             DIO output enable, 1 = drive            |
// |   keys         in   8*READ_BYTES  key-scan source, byte n = [8n+7:8n]     |
// |   disp_mem     out  8*MEM_BYTES   display memory, byte a = [8a+7:8a]      |
// |   display_on   out  1             display-control bit 3                   |
// |   brightness   out  3             display-control bits [2:0]              |
// |   byte_strobe  out  1             pulse per complete received byte        |
// |   frame_err    out  1             pulse when cs rises on a partial byte   |
// +---------------------------------------------------------------------------+
module tm1638_responder #(
  parameter int MEM_BYTES   = 16,
  parameter int READ_BYTES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    sck,
  input  logic                    cs,
  input  logic                    dio_i,
  output logic                    dio_o,
  output logic                    dio_e,
  input  logic [8*READ_BYTES-1:0] keys,
  output logic [8*MEM_BYTES-1:0]  disp_mem,
  output logic                    display_on,
  output logic [2:0]              brightness,
  output logic                    byte_strobe,
  output logic                    frame_err
);

  localparam int c_AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int c_RW = (READ_BYTES > 0) ? $clog2(8 * READ_BYTES) : 1;

  localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(MEM_BYTES - 1);
  localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
  localparam logic [c_RW-1:0] c_RD_LAST   = c_RW'(8 * READ_BYTES - 1);
  localparam logic [c_RW-1:0] c_RD_ONE    = c_RW'(1);
  localparam logic [2:0]      c_BIT_LAST  = 3'd7;

  typedef enum logic [2:0] {
    S_WAIT_HIGH = 3'd0,
    S_IDLE      = 3'd1,
    S_CMD       = 3'd2,
    S_WRITE     = 3'd3,
    S_READ      = 3'd4,
    S_IGNORE    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection.
  // The chains clear to 0 so that after reset cs is treated as "not yet seen
  // high"; S_WAIT_HIGH then waits for a real high level on the pin.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_dio_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic w_sck;
  logic w_cs;
  logic w_dio;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '0;
      r_dio_sync <= '0;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], dio_i};
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_dio      = r_dio_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck &  r_sck_d;
  assign w_cs_rise  =  w_cs  & ~r_cs_d;
  assign w_cs_fall  = ~w_cs  &  r_cs_d;

  // ---------------------------------------------------------------------------
  // Qualified events. A cs rise ends the frame and masks any sck edge that
  // lands in the same cycle.
  // ---------------------------------------------------------------------------
  logic w_in_frame;
  logic w_cs_end;
  logic w_rise_ok;
  logic w_fall_ok;

  assign w_in_frame = (r_state == S_CMD)  || (r_state == S_WRITE) ||
                      (r_state == S_READ) || (r_state == S_IGNORE);
  assign w_cs_end   = w_cs_rise && (r_state != S_WAIT_HIGH);
  assign w_rise_ok  = w_sck_rise && w_in_frame && !w_cs_end;
  assign w_fall_ok  = w_sck_fall && w_in_frame && !w_cs_end;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [7:0]                   r_shift;
  logic [2:0]                   r_bit_cnt;
  logic                         r_byte_strobe;
  logic                         r_frame_err;
  logic                         r_fixed;
  logic [c_AW-1:0]              r_ptr;
  logic [MEM_BYTES-1:0][7:0]    r_mem;
  logic                         r_display_on;
  logic [2:0]                   r_brightness;
  logic [8*READ_BYTES-1:0]      r_snap;
  logic [c_RW-1:0]              r_rd_cnt;
  logic                         r_dio_o;
  logic                         r_dio_e;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state <= S_WAIT_HIGH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The command byte is decoded in the cycle its
  // byte_strobe is high, when r_shift holds the complete byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT_HIGH: begin
        if (w_cs) begin
          w_next_state = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_cs_fall) begin
          w_next_state = S_CMD;
        end
      end
      S_CMD: begin
        if (r_byte_strobe) begin
          case (r_shift[7:6])
            2'b01:   w_next_state = r_shift[1] ? S_READ : S_IGNORE;
            2'b11:   w_next_state = S_WRITE;
            default: w_next_state = S_IGNORE;
          endcase
        end
      end
      S_READ: begin
        if (w_rise_ok && (r_rd_cnt == c_RD_LAST)) begin
          w_next_state = S_IGNORE;
        end
      end
      default: begin
        w_next_state = r_state;
      end
    endcase
    if (w_cs_end) begin
      w_next_state = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit capture, command decode, memory write and read-back drive
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_byte_strobe <= 1'b0;
      r_frame_err   <= 1'b0;
      r_fixed       <= 1'b0;
      r_ptr         <= '0;
      r_mem         <= '0;
      r_display_on  <= 1'b0;
      r_brightness  <= '0;
      r_snap        <= '0;
      r_rd_cnt      <= '0;
      r_dio_o       <= 1'b0;
      r_dio_e       <= 1'b0;
    end else begin
      r_byte_strobe <= 1'b0;
      r_frame_err   <= 1'b0;

      if (w_cs_end) begin
        // A non-zero bit count means a byte was cut short; it is dropped.
        r_frame_err <= (r_bit_cnt != 3'd0);
        r_bit_cnt   <= '0;
        r_rd_cnt    <= '0;
        r_dio_e     <= 1'b0;
        r_dio_o     <= 1'b0;
      end else begin
        if ((r_state == S_IDLE) && w_cs_fall) begin
          r_bit_cnt <= '0;
        end

        if (w_rise_ok) begin
          r_shift   <= {w_dio, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          // Bits clocked during read-back are our own data, not a received byte.
          if ((r_bit_cnt == c_BIT_LAST) && (r_state != S_READ)) begin
            r_byte_strobe <= 1'b1;
          end
        end

        if (r_state == S_READ) begin
          // r_rd_cnt counts rises already sampled, so it is also the index
          // of the bit to present on the next fall.
          if (w_fall_ok) begin
            r_dio_e <= 1'b1;
            r_dio_o <= r_snap[r_rd_cnt];
          end
          if (w_rise_ok) begin
            if (r_rd_cnt == c_RD_LAST) begin
              r_rd_cnt <= '0;
              r_dio_e  <= 1'b0;
              r_dio_o  <= 1'b0;
            end else begin
              r_rd_cnt <= r_rd_cnt + c_RD_ONE;
            end
          end
        end
      end

      // A completed byte takes effect even if cs rises in the same cycle.
      if (r_byte_strobe) begin
        if (r_state == S_CMD) begin
          case (r_shift[7:6])
            2'b01: begin
              r_fixed <= r_shift[2];
              if (r_shift[1]) begin
                r_snap   <= keys;
                r_rd_cnt <= '0;
              end
            end
            2'b10: begin
              r_display_on <= r_shift[3];
              r_brightness <= r_shift[2:0];
            end
            2'b11: begin
              r_ptr <= r_shift[c_AW-1:0];
            end
            default: begin
            end
          endcase
        end else if (r_state == S_WRITE) begin
          r_mem[r_ptr] <= r_shift;
          if (!r_fixed) begin
            r_ptr <= (r_ptr == c_LAST_ADDR) ? '0 : (r_ptr + c_PTR_ONE);
          end
        end
      end
    end
  end

  assign disp_mem    = r_mem;
  assign display_on  = r_display_on;
  assign brightness  = r_brightness;
  assign byte_strobe = r_byte_strobe;
  assign frame_err   = r_frame_err;
  assign dio_o       = r_dio_o;
  assign dio_e       = r_dio_e;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_tm1638_responder                                         |
// | Description : Self-checking bench for tm1638_responder. Acts as the       |
// |               TM1638 controller, keeps a byte-level reference model and   |
// |               checks display state and read-back through scoreboards.     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_tm1638_responder;

  localparam int H = 6;  // sck half period in system clocks

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         sck;
  logic         cs;
  logic         tb_dio;
  logic [31:0]  keys;
  logic         dio_o;
  logic         dio_e;
  logic         dio_bus;
  logic [127:0] disp_mem;
  logic         display_on;
  logic [2:0]   brightness;
  logic         byte_strobe;
  logic         frame_err;

  always #10 CLOCK_50 = ~CLOCK_50;

  // Open-drain style bus: responder drives when enabled, else controller/pull-up.
  assign dio_bus = dio_e ? dio_o : tb_dio;

  tm1638_responder #(
    .MEM_BYTES  (16),
    .READ_BYTES (4),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .sck        (sck),
    .cs         (cs),
    .dio_i      (dio_bus),
    .dio_o      (dio_o),
    .dio_e      (dio_e),
    .keys       (keys),
    .disp_mem   (disp_mem),
    .display_on (display_on),
    .brightness (brightness),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err)
  );

  typedef struct packed {
    logic [127:0] mem;
    logic         on;
    logic [2:0]   br;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] frame_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_mem [16];
  bit         m_fixed;
  int         m_ptr;
  bit         m_on;
  bit [2:0]   m_br;
  bit         m_write_frame;
  int         exp_ferr = 0;
  int         seen_ferr = 0;
  bit         rd_active = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t s;
    for (int a = 0; a < 16; a++) s.mem[8*a +: 8] = m_mem[a];
    s.on = m_on;
    s.br = m_br;
    return s;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 16; a++) m_mem[a] = 8'h00;
    m_fixed = 1'b0;
    m_ptr   = 0;
    m_on    = 1'b0;
    m_br    = 3'd0;
    m_write_frame = 1'b0;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    m_write_frame = 1'b0;
    case (b[7:6])
      2'b01: m_fixed = b[2];
      2'b10: begin m_on = b[3]; m_br = b[2:0]; end
      2'b11: begin m_ptr = int'(b[3:0]); m_write_frame = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic model_data(input logic [7:0] b);
    if (m_write_frame) begin
      m_mem[m_ptr] = b;
      if (!m_fixed) m_ptr = (m_ptr + 1) % 16;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b0; tb_dio = b[i];
      wait_clk(H);
      sck = 1'b1;
      wait_clk(H);
    end
  endtask

  // Sends frame_q as one cs frame; the first byte is the command.
  task automatic send_frame();
    cs = 1'b0;
    wait_clk(H);
    for (int k = 0; k < frame_q.size(); k++) begin
      if (k == 0) model_cmd(frame_q[k]);
      else        model_data(frame_q[k]);
      exp_q.push_back(snapshot());
      send_bits(frame_q[k], 8);
    end
    tb_dio = 1'b1;
    wait_clk(H);
    cs = 1'b1;
    wait_clk(3 * H);
  endtask

  task automatic frame1(input logic [7:0] b0);
    frame_q.delete();
    frame_q.push_back(b0);
    send_frame();
  endtask

  task automatic read_frame(input logic [7:0] cmd);
    cs = 1'b0;
    wait_clk(H);
    model_cmd(cmd);
    exp_q.push_back(snapshot());
    for (int i = 0; i < 4; i++) rd_q.push_back(keys[8*i +: 8]);
    send_bits(cmd, 8);
    rd_active = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sck = 1'b0; tb_dio = 1'b1;
      wait_clk(H);
      sck = 1'b1;
      if (i == 31) begin
        wait_clk(5);
        chk("dio_e_after_last_rise", 128'(dio_e), 128'(0));
        wait_clk(H - 5);
      end else begin
        wait_clk(H);
      end
    end
    rd_active = 1'b0;
    cs = 1'b1;
    wait_clk(5);
    chk("dio_e_after_cs_rise", 128'(dio_e), 128'(0));
    wait_clk(3 * H);
  endtask

  task automatic abort_frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits);
    cs = 1'b0;
    wait_clk(H);
    model_cmd(cmd);
    exp_q.push_back(snapshot());
    send_bits(cmd, 8);
    send_bits(data, nbits);
    tb_dio = 1'b1;
    wait_clk(H);
    cs = 1'b1;
    exp_ferr++;
    wait_clk(3 * H);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_disp_mem"},    disp_mem, 128'(0));
    chk({tag, "_display"},     128'({display_on, brightness}), 128'(0));
    chk({tag, "_dio_e"},       128'(dio_e), 128'(0));
    chk({tag, "_dio_o"},       128'(dio_o), 128'(0));
    chk({tag, "_byte_strobe"}, 128'(byte_strobe), 128'(0));
    chk({tag, "_frame_err"},   128'(frame_err), 128'(0));
  endtask

  // Display-state scoreboard: one expected entry per received byte.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (byte_strobe === 1'b1) begin
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte_strobe_unexpected actual=strobe required=none at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("disp_mem", disp_mem, mon_e.mem);
          chk("display_ctrl", 128'({display_on, brightness}), 128'({mon_e.on, mon_e.br}));
        end
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (frame_err === 1'b1) seen_ferr++;
  end

  // Read-back scoreboard: samples DIO on sck rise as the controller would.
  logic [7:0] rd_byte = 8'h00;
  int         rd_bits = 0;
  initial begin
    forever begin
      @(posedge sck);
      if (rd_active) begin
        rd_byte = {dio_bus, rd_byte[7:1]};
        rd_bits++;
        if (rd_bits == 8) begin
          rd_bits = 0;
          if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_byte_unexpected actual=%0h required=none", rd_byte);
          end else begin
            chk("read_byte", 128'(rd_byte), 128'(rd_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [7:0] c;
  int         sel;
  int         n;

  initial begin
    reset = 1'b0; cs = 1'b1; sck = 1'b1; tb_dio = 1'b1; keys = 32'h0;
    model_reset();
    wait_clk(6);
    check_reset_outputs("reset");
    reset = 1'b1;
    wait_clk(10);

    // Auto-increment fill of the whole memory
    frame1(8'h40);
    frame_q.delete();
    frame_q.push_back(8'hC0);
    for (int i = 1; i <= 16; i++) frame_q.push_back(8'(i));
    send_frame();

    // Fixed address: only byte 5 keeps the last value
    frame1(8'h44);
    frame_q = '{8'hC5, 8'hAA, 8'hBB, 8'hCC};
    send_frame();

    // Auto-increment wrap 15 -> 0
    frame1(8'h40);
    frame_q = '{8'hCF, 8'h11, 8'h22};
    send_frame();

    // Display control
    frame1(8'h8B);
    frame1(8'h80);

    // Key read
    keys = 32'hA5C3_0F81;
    read_frame(8'h42);

    // Partial byte then a normal frame
    abort_frame(8'hC3, 8'h5A, 5);
    chk("frame_err_count_directed", 128'(seen_ferr), 128'(exp_ferr));
    frame_q = '{8'hC3, 8'h77};
    send_frame();

    // Reset in the middle of a read
    keys = 32'h1234_5678;
    cs = 1'b0;
    wait_clk(H);
    model_cmd(8'h42);
    exp_q.push_back(snapshot());
    send_bits(8'h42, 8);
    for (int i = 0; i < 5; i++) begin
      sck = 1'b0; tb_dio = 1'b1;
      wait_clk(H);
      sck = 1'b1;
      wait_clk(H);
    end
    chk("dio_e_driving_mid_read", 128'(dio_e), 128'(1));
    reset = 1'b0;
    wait_clk(1);
    chk("dio_e_first_reset_cycle", 128'(dio_e), 128'(0));
    wait_clk(3);
    model_reset();
    check_reset_outputs("mid_reset");
    reset = 1'b1;
    for (int i = 5; i < 32; i++) begin
      sck = 1'b0;
      wait_clk(H);
      sck = 1'b1;
      wait_clk(H);
    end
    cs = 1'b1;
    wait_clk(3 * H);
    frame_q = '{8'hC4, 8'h5E, 8'h6F};
    send_frame();
    frame1(8'h8F);

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 5);
      frame_q.delete();
      case (sel)
        0: begin
          c = 8'($urandom_range(0, 255));
          c[7] = 1'b0;
          c[1] = 1'b0;
          frame_q.push_back(c);
          n = $urandom_range(0, 1);
          for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
          send_frame();
        end
        1, 2: begin
          frame_q.push_back(8'hC0 | 8'($urandom_range(0, 15)));
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
          send_frame();
        end
        3: begin
          frame_q.push_back(8'h80 | 8'($urandom_range(0, 63)));
          n = $urandom_range(0, 1);
          for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
          send_frame();
        end
        4: begin
          keys = $urandom;
          c = 8'h42;
          c[2] = 1'($urandom_range(0, 1));
          c[3] = 1'($urandom_range(0, 1));
          read_frame(c);
        end
        default: begin
          c = 8'($urandom_range(0, 255));
          if (c[7:6] == 2'b01) c[1] = 1'b0;
          abort_frame(c, 8'($urandom_range(0, 255)), $urandom_range(1, 7));
        end
      endcase
    end

    wait_clk(10 * H);
    chk("frame_err_count_total", 128'(seen_ferr), 128'(exp_ferr));
    chk("byte_queue_drained", 128'(exp_q.size()), 128'(0));
    chk("read_queue_drained", 128'(rd_q.size()), 128'(0));
    chk("final_disp_mem", disp_mem, snapshot().mem);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
